// File: rtl/clkdiv_if.sv
// clkdiv_if: configuration handshake and divider outputs for clkdiv_ctrl.
//   en        run request (level)
//   cfg_valid new divide ratio offered
//   cfg_div   requested ratio N
//   cfg_ready controller can take a ratio
//   div_clk   divided clock (registered)
//   div_tick  one-cycle pulse at the start of each period (registered)
//   busy      controller not idle
//   cfg_err   one-cycle pulse when an accepted ratio was below 2
// master drives requests (system side), slave is the controller.
interface clkdiv_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             div_clk;
  logic             div_tick;
  logic             busy;
  logic             cfg_err;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, div_clk, div_tick, busy, cfg_err
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, div_clk, div_tick, busy, cfg_err
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable clock-enable divider with glitch-free start/stop.
// Produces a divided square wave (high floor(N/2), low ceil(N/2) cycles) and a
// period-start tick. New ratios are taken through a valid/ready handshake and
// only applied at a period boundary (or immediately while idle).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  clkdiv_if slave: en, cfg_valid/cfg_div/cfg_ready, div_clk, div_tick,
//        busy, cfg_err
module clkdiv_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  clkdiv_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             div_clk_q, div_clk_d;
  logic             div_tick_q, div_tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   half;
  logic             wrap;
  logic             xfer;
  logic             cfg_low;

  // Widened by one bit so cnt+1 never wraps before the compares.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign half    = {1'b0, ratio_q >> 1};
  assign wrap    = (cnt_inc == {1'b0, ratio_q});
  assign xfer    = bus.cfg_valid && !pend_q;
  assign cfg_low = (bus.cfg_div < CNT_W'(2));

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    div_clk_d  = 1'b0;
    div_tick_d = 1'b0;
    cfg_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          ratio_d = pend_div_q;
          pend_d  = 1'b0;
        end
        if (bus.en) begin
          state_d    = RUN;
          div_clk_d  = 1'b1;
          div_tick_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          cnt_d = '0;
          // Pending ratio only ever lands here so a period is never cut short.
          if (pend_q) begin
            ratio_d = pend_div_q;
            pend_d  = 1'b0;
          end
          if (state_q == DRAIN && !bus.en) begin
            state_d = IDLE;
          end else begin
            state_d    = bus.en ? RUN : DRAIN;
            div_clk_d  = 1'b1;
            div_tick_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_inc[CNT_W-1:0];
          div_clk_d = (cnt_inc < half);
          state_d   = bus.en ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Transfer and apply are exclusive: transfer needs !pend, apply needs pend.
    if (xfer) begin
      pend_d     = 1'b1;
      pend_div_d = cfg_low ? CNT_W'(2) : bus.cfg_div;
      cfg_err_d  = cfg_low;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ratio_q    <= CNT_W'(DEF_DIV);
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= CNT_W'(DEF_DIV);
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.cfg_ready = !pend_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.div_clk   = div_clk_q;
  assign bus.div_tick  = div_tick_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: self-checking bench for clkdiv_ctrl. A period-level model
// (running flag, position within the period, ratio, pending ratio) predicts
// every output after each clock edge; scenario tasks add directed checks.
module tb_clkdiv_ctrl;
  localparam int unsigned CntW   = 8;
  localparam int unsigned DefDiv = 4;

  logic clk = 1'b0;
  logic rst;

  clkdiv_if #(.CNT_W(CntW)) bus ();

  clkdiv_ctrl #(
    .CNT_W   (CntW),
    .DEF_DIV (DefDiv)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: where we are inside the current period.
  bit          m_run, m_drain, m_pend, m_err;
  int unsigned m_pos, m_n, m_pend_div;

  function automatic void m_reset();
    m_run = 1'b0; m_drain = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_pos = 0; m_n = DefDiv; m_pend_div = DefDiv;
  endfunction

  // {div_clk, div_tick, busy, cfg_ready, cfg_err}
  function automatic logic [4:0] exp_vec();
    return {m_run && (m_pos < m_n / 2), m_run && (m_pos == 0), m_run, !m_pend, m_err};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {bus.div_clk, bus.div_tick, bus.busy, bus.cfg_ready, bus.cfg_err};
  endfunction

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic step(input logic en_v, input logic valid_v, input logic [CntW-1:0] div_v);
    bit xfer;
    bus.en = en_v; bus.cfg_valid = valid_v; bus.cfg_div = div_v;
    @(posedge clk);
    xfer = valid_v && !m_pend;
    if (!m_run) begin
      if (m_pend) begin m_n = m_pend_div; m_pend = 1'b0; end
      if (en_v) begin m_run = 1'b1; m_pos = 0; end
      m_drain = 1'b0;
    end else begin
      if (m_pos == m_n - 1) begin
        if (m_pend) begin m_n = m_pend_div; m_pend = 1'b0; end
        m_pos = 0;
        // The period in which en was released is the last one.
        if (m_drain && !en_v) m_run = 1'b0;
      end else begin
        m_pos++;
      end
      m_drain = m_run && !en_v;
    end
    if (xfer) begin
      m_pend = 1'b1;
      m_pend_div = (div_v < 2) ? 2 : int'(div_v);
    end
    m_err = xfer && (div_v < 2);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
    #1;
    checks++;
    if (obs_vec() !== 5'b00010) begin
      failures++; $display("FAIL reset_async got=%b exp=00010", obs_vec());
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_default_run();
    logic [3:0] pat;
    pat = 4'b0011;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL default_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.busy} !== {pat[i % 4], (i % 4) == 0, 1'b1}) begin
        failures++;
        $display("FAIL default_pattern cyc=%0d got=%b%b%b exp=%b%b1", i, bus.div_clk,
                 bus.div_tick, bus.busy, pat[i % 4], (i % 4) == 0);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [4:0] pat5;
    pat5 = 5'b00011;
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'd5);  // taken while cnt==1
    checks++;
    if (bus.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL ratio_ready_low got=%b exp=0", bus.cfg_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if ({bus.div_tick, bus.cfg_ready} !== {i == 1, i == 1}) begin
        failures++;
        $display("FAIL ratio_old_period i=%0d got=%b%b exp=%b%b", i, bus.div_tick,
                 bus.cfg_ready, i == 1, i == 1);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if ({bus.div_clk, bus.div_tick} !== {pat5[i % 5], i == 5}) begin
        failures++;
        $display("FAIL ratio_new_period i=%0d got=%b%b exp=%b%b", i, bus.div_clk,
                 bus.div_tick, pat5[i % 5], i == 5);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL ratio_model i=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'd1);
    checks++;
    if ({bus.cfg_err, bus.cfg_ready} !== 2'b10) begin
      failures++; $display("FAIL err_pulse got=%b%b exp=10", bus.cfg_err, bus.cfg_ready);
    end
    step(1'b1, 1'b0, '0);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("FAIL err_one_cycle got=%b exp=0", bus.cfg_err);
    end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    checks++;
    if (bus.div_tick !== 1'b1) begin
      failures++; $display("FAIL err_old_wrap got=%b exp=1", bus.div_tick);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if ({bus.div_clk, bus.div_tick} !== {(i % 2) == 0, (i % 2) == 0}) begin
        failures++;
        $display("FAIL err_ratio2 i=%0d got=%b%b exp=%b%b", i, bus.div_clk, bus.div_tick,
                 (i % 2) == 0, (i % 2) == 0);
      end
    end
    step(1'b1, 1'b1, 8'd3);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("FAIL err_valid3 got=%b exp=0", bus.cfg_err);
    end
    step(1'b1, 1'b0, '0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if ({bus.div_clk, bus.div_tick} !== {i == 3, i == 3}) begin
        failures++;
        $display("FAIL err_ratio3 i=%0d got=%b%b exp=%b%b", i, bus.div_clk, bus.div_tick,
                 i == 3, i == 3);
      end
    end
  endtask

  task automatic test_drain();
    logic en_pat;
    do_reset();
    step(1'b0, 1'b1, 8'd6);
    step(1'b0, 1'b0, '0);
    checks++;
    if ({bus.busy, bus.cfg_ready} !== 2'b01) begin
      failures++; $display("FAIL drain_idle_apply got=%b%b exp=01", bus.busy, bus.cfg_ready);
    end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, '0);  // en drops while cnt==1
      checks++;
      if ({bus.div_clk, bus.busy, bus.div_tick} !== {i == 0, i < 4, 1'b0}) begin
        failures++;
        $display("FAIL drain_stop i=%0d got=%b%b%b exp=%b%b0", i, bus.div_clk, bus.busy,
                 bus.div_tick, i == 0, i < 4);
      end
    end
    // Re-raise en mid-drain: the waveform must not break.
    for (int i = 0; i < 7; i++) begin
      en_pat = !(i == 2 || i == 3);
      step(en_pat, 1'b0, '0);
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.busy} !== {i < 3 || i == 6, i == 0 || i == 6, 1'b1})
      begin
        failures++;
        $display("FAIL drain_resume i=%0d got=%b%b%b exp=%b%b1", i, bus.div_clk, bus.div_tick,
                 bus.busy, i < 3 || i == 6, i == 0 || i == 6);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL drain_model i=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b1, 8'd7);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'd9);
    checks++;
    if (bus.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_pending got=%b exp=0", bus.cfg_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 5'b00010) begin
      failures++; $display("FAIL rstmid_async got=%b exp=00010", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (bus.div_tick !== ((i % 4) == 0)) begin
        failures++;
        $display("FAIL rstmid_period i=%0d got=%b exp=%b", i, bus.div_tick, (i % 4) == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs_cnt;
    int periods;
    logic hs;
    do_reset();
    hs_cnt = 0;
    periods = 0;
    for (int i = 0; i < 80; i++) begin
      hs = bus.cfg_ready;  // cfg_valid is held, so ready-before-edge means a transfer
      step(1'b1, 1'b1, (i % 2) ? 8'd5 : 8'd3);
      if (hs) hs_cnt++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      if (bus.div_tick) begin
        if (periods >= 2) begin
          checks++;
          if (hs_cnt !== 1) begin
            failures++; $display("FAIL b2b_one_per_wrap cyc=%0d got=%0d exp=1", i, hs_cnt);
          end
        end
        hs_cnt = 0;
        periods++;
      end
    end
  endtask

  task automatic test_random();
    logic en_r;
    do_reset();
    en_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) en_r = !en_r;
      step(en_r, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 9)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_default_run();
    test_ratio_change();
    test_cfg_err();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable clock-enable divider controller for the clock-buffer path. It derives a divided square wave (`div_clk`) and a one-cycle period tick (`div_tick`) from the system clock. The divide ratio is reconfigured only on period boundaries through a valid/ready handshake. Start and stop are glitch-free, so downstream buffers never see a runt pulse and the frequency/phase bench measures clean periods.

## Interface
- `CNT_W`, default 8: width of the ratio and the period counter.
- `DEF_DIV`, default 4: divide ratio loaded at reset; must be in 2..2^CNT_W-1.
- `clk`  input  1: system clock; all logic on its rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `en`  input  1: run request; level-sensitive.
- `cfg_valid`  input  1: new ratio offered.
- `cfg_div`  input  CNT_W: requested ratio N.
- `cfg_ready`  output  1: controller can accept a ratio.
- `div_clk`  output  1: divided clock (registered).
- `div_tick`  output  1: one-cycle pulse at the start of each period (registered).
- `busy`  output  1: state is not IDLE.
- `cfg_err`  output  1: one-cycle pulse when an accepted `cfg_div` is below 2.

## Operation
- **Registers:**
  - `ratio`: active N.
  - `pend_div`, `pend`: pending ratio.
  - `cnt`: 0..ratio-1.
  - `state`: one of IDLE, RUN, DRAIN.
- **Reset values:**
  - `state`=IDLE, `ratio`=DEF_DIV, `cnt`=0, `pend`=0.
  - `div_clk`=0, `div_tick`=0, `busy`=0, `cfg_ready`=1, `cfg_err`=0.
- **Handshake:**
  - `cfg_ready` = !`pend`.
  - A transfer occurs on an edge with `cfg_valid` && `cfg_ready`: `pend_div`<=`cfg_div`, `pend`<=1.
  - `cfg_div` of 0 or 1 is coerced to 2 and `cfg_err` pulses for one cycle.
- **Applying a pending ratio:**
  - In IDLE, it is applied on the next edge.
  - In RUN/DRAIN, it is applied only on the wrap edge (`cnt`==`ratio`-1), where `ratio`<=`pend_div` and `pend`<=0.
- **IDLE:**
  - `div_clk`=0, `div_tick`=0, `cnt`=0.
  - `en`=1 -> RUN with `cnt`<=0, `div_clk`<=1, `div_tick`<=1.
- **RUN, each edge:**
  - On wrap: `cnt`<=0, `div_clk`<=1, `div_tick`<=1.
  - Otherwise: `cnt`<=`cnt`+1, `div_clk`<=((`cnt`+1) < (`ratio`>>1)), `div_tick`<=0.
  - `en`=0 -> DRAIN; the count continues.
- **DRAIN:**
  - Counts the same way as RUN but does not restart.
  - On wrap: -> IDLE with `div_clk`<=0, `div_tick`<=0, `cnt`<=0.
  - `en`=1 during DRAIN -> RUN with no interruption of the current period.
- **Duty cycle:** high for floor(N/2) cycles, low for ceil(N/2) cycles. N=2 gives 1/1; N=3 gives 1/2.
- **Pending ratio at a wrap:** when a pending ratio is applied on a wrap edge, that edge's `div_clk`/`div_tick` use the restart values, and the new period runs with the new ratio from `cnt`=0.
- **Simultaneous events:** a cfg transfer on the same edge as a wrap is not applied at that wrap; it waits for the next wrap.
- **Arithmetic:** `cnt`+1 is computed in CNT_W+1 bits; compares are unsigned.

## Timing
- **Start latency:** `en` sampled high in IDLE at edge k -> `div_clk`=1 and `div_tick`=1 after edge k. Latency is 1 cycle.
- **Period:** exactly `ratio` clk cycles between successive `div_tick` pulses.
- **Stop:** `en` low -> `div_clk` falls to 0 no earlier than the end of the current full period. `busy` drops on the same edge as the return to IDLE.
- **Ratio change:** takes effect at the first wrap after the transfer edge, with a worst case of one full old period.
- **Reset mid-operation:** `rst` asserted forces all outputs to their reset values immediately, asynchronously. Any pending config is discarded and `ratio` returns to DEF_DIV.

## Test plan
- Reset, then `en`=1 with DEF_DIV=4 -> `div_tick` every 4 cycles, `div_clk` pattern 1,1,0,0 repeating, `busy`=1 from cycle 1.
- In RUN at N=4, transfer `cfg_div`=5 at `cnt`=1 -> period stays 4 until the wrap, then 5 (1,1,0,0,0); `cfg_ready`=0 for that interval, then returns to 1.
- Transfer `cfg_div`=1 -> `cfg_err` pulses for one cycle; active ratio becomes 2 (pattern 1,0); a transfer of 3 gives pattern 1,0,0.
- Drop `en` at `cnt`=1 with N=6 -> `div_clk` completes 1,1,1,0,0,0 and then stays 0; `busy` falls at the wrap; re-raising `en` during DRAIN gives a continuous waveform.
- Assert `rst` mid-period with N=7 and a pending config -> outputs 0 and `cfg_ready`=1 immediately; after release plus `en`, the period is 4.
- Hold `cfg_valid` continuously with alternating values -> exactly one transfer per wrap and no dropped handshake.
